// File: rtl/register_serial_transmitter.sv
// rtl/register_serial_transmitter.sv - PISO serial transmitter, LSB-first; optional parity via PARITY_EN
module register_serial_transmitter #(
  parameter int W            = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset_asynchronous_n,
  input  logic         inp_valid,
  input  logic [W-1:0] inp_data,
  output logic         inp_ready,
  output logic         serial_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(W + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          serial_out_q, serial_out_d;
  logic          done_q, done_d;
  logic          bit_term;
`ifdef PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign inp_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign serial_out = serial_out_q;
  assign done       = done_q;
  assign bit_term   = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    idx_d        = idx_q;
    serial_out_d = serial_out_q;
    done_d       = 1'b0;
`ifdef PARITY_EN
    parity_d     = parity_q;
`endif
    if (state_q != ST_IDLE) begin
      bit_cnt_d = bit_term ? '0 : bit_cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        serial_out_d = 1'b1;
        bit_cnt_d    = '0;
        idx_d        = '0;
        if (inp_valid) begin
          shreg_d      = inp_data;
          serial_out_d = 1'b0;
          state_d      = ST_START;
`ifdef PARITY_EN
          parity_d     = ^inp_data;
`endif
        end
      end
      ST_START: begin
        if (bit_term) begin
          serial_out_d = shreg_q[0];
          shreg_d      = shreg_q >> 1;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_term) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef PARITY_EN
            serial_out_d = parity_q;
            state_d      = ST_PARITY;
`else
            serial_out_d = 1'b1;
            state_d      = ST_STOP;
`endif
          end else begin
            idx_d        = idx_q + 1'b1;
            serial_out_d = shreg_q[0];
            shreg_d      = shreg_q >> 1;
          end
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (bit_term) begin
          serial_out_d = 1'b1;
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_term) begin
          serial_out_d = 1'b1;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        serial_out_d = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      serial_out_q <= 1'b1;
      done_q       <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      serial_out_q <= serial_out_d;
      done_q       <= done_d;
`ifdef PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_register_serial_transmitter.sv
// tb/tb_register_serial_transmitter.sv - directed bench for register_serial_transmitter (W=4/CPB=4 and W=8/CPB=1)
module tb_register_serial_transmitter;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NB        = 7;
  localparam int NB8       = 11;
  localparam logic [10:0] SEQ_A5 = 11'b10101001010;
`else
  localparam int NB        = 6;
  localparam int NB8       = 10;
  localparam logic [10:0] SEQ_A5 = 11'b01101001010;
`endif
  localparam int FRAME_LEN = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inp_valid, inp_ready, serial_out, busy, done;
  logic [3:0] inp_data;
  logic       v8, r8, so8, busy8, done8;
  logic [7:0] d8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_serial_transmitter #(.W(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset_asynchronous_n(rst_n), .inp_valid(inp_valid), .inp_data(inp_data),
    .inp_ready(inp_ready), .serial_out(serial_out), .busy(busy), .done(done));

  register_serial_transmitter #(.W(8), .CLKS_PER_BIT(1)) dut8 (
    .clk(clk), .reset_asynchronous_n(rst_n), .inp_valid(v8), .inp_data(d8),
    .inp_ready(r8), .serial_out(so8), .busy(busy8), .done(done8));

  typedef struct {
    logic [3:0] data;
    logic [5:0] seq;
    logic       par;
    bit         inject;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called right after the accepting edge; returns at the negedge where done is first seen.
  task automatic run_frame(input logic [5:0] seq6, input logic par, input logic [3:0] next_data,
                           input logic keep_valid, input bit inject, input string tag);
    logic [63:0] cap, exp;
    logic [NB-1:0] seq;
    int lat;
    cap = '0;
    exp = '0;
    lat = -1;
`ifdef PARITY_EN
    seq = {1'b1, par, seq6[4:0]};
`else
    seq = seq6;
`endif
    for (int i = 0; i < NB * CPB; i++) exp[i] = seq[i / CPB];
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin
        inp_data  = next_data;
        inp_valid = keep_valid;
        check({tag, "_busy"}, 64'(busy), 64'd1);
      end
      if (inject && n == 10) begin
        check({tag, "_ready_busy"}, 64'(inp_ready), 64'd0);
        inp_valid = 1'b1;
        inp_data  = 4'hF;
      end
      if (inject && n == 11) inp_valid = 1'b0;
      if (n <= NB * CPB) cap[n-1] = serial_out;
      if (done) begin
        lat = n - 1;
        break;
      end
    end
    check({tag, "_line"}, cap, exp);
    check({tag, "_latency"}, 64'(lat), 64'(FRAME_LEN));
    check({tag, "_idle_high"}, 64'(serial_out), 64'd1);
  endtask

  task automatic send(input logic [3:0] data, input logic [5:0] seq6, input logic par,
                      input bit inject, input string tag);
    @(negedge clk);
    inp_valid = 1'b1;
    inp_data  = data;
    check({tag, "_ready"}, 64'(inp_ready), 64'd1);
    @(posedge clk);
    run_frame(seq6, par, ~data, 1'b0, inject, tag);
  endtask

  initial begin
    vecs[0] = '{data: 4'b1010, seq: 6'b110100, par: 1'b0, inject: 1'b0};
    vecs[1] = '{data: 4'h0,    seq: 6'b100000, par: 1'b0, inject: 1'b1};
    vecs[2] = '{data: 4'hF,    seq: 6'b111110, par: 1'b0, inject: 1'b0};
    vecs[3] = '{data: 4'b0111, seq: 6'b101110, par: 1'b1, inject: 1'b0};
    vecs[4] = '{data: 4'b0001, seq: 6'b100010, par: 1'b1, inject: 1'b0};

    inp_valid = 1'b0;
    inp_data  = 4'h0;
    v8        = 1'b0;
    d8        = 8'h00;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("rst_serial", 64'(serial_out), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(inp_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_serial8", 64'(so8), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, vecs[i].seq, vecs[i].par, vecs[i].inject, $sformatf("vec%0d", i));
    end
    repeat (3) @(negedge clk);
    check("inject_no_frame", 64'({busy, serial_out}), 64'b01);

    // Back-to-back: valid held high, second word taken in the done cycle.
    @(negedge clk);
    inp_valid = 1'b1;
    inp_data  = 4'h3;
    @(posedge clk);
    run_frame(6'b100110, 1'b0, 4'hC, 1'b1, 1'b0, "b2b_a");
    check("b2b_ready_in_done", 64'(inp_ready), 64'd1);
    @(posedge clk);
    run_frame(6'b111000, 1'b0, 4'hC, 1'b0, 1'b0, "b2b_b");

    // Asynchronous reset in the middle of DATA.
    @(negedge clk);
    inp_valid = 1'b1;
    inp_data  = 4'hA;
    @(posedge clk);
    @(negedge clk);
    inp_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_in_frame", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_serial", 64'(serial_out), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(inp_ready), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (done || busy || !serial_out) seen = 1'b1;
      end
      check("mid_rst_quiet", 64'(seen), 64'd0);
    end
    send(vecs[0].data, vecs[0].seq, vecs[0].par, 1'b0, "after_rst");

    // W=8, one clock per bit.
    begin
      logic [63:0] cap, exp;
      int lat;
      cap = '0;
      exp = '0;
      lat = -1;
      for (int i = 0; i < NB8; i++) exp[i] = SEQ_A5[i];
      @(negedge clk);
      v8 = 1'b1;
      d8 = 8'hA5;
      check("w8_ready", 64'(r8), 64'd1);
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (n == 1) begin
          v8 = 1'b0;
          d8 = 8'h00;
        end
        if (n <= NB8) cap[n-1] = so8;
        if (done8) begin
          lat = n - 1;
          break;
        end
      end
      check("w8_line", cap, exp);
      check("w8_latency", 64'(lat), 64'(NB8));
      check("w8_idle", 64'({busy8, so8}), 64'b01);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
